// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared size codes, FSM states and alignment check for the RAM bridge.
package mem_bridge_pkg;
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   // Size 2'b11 is handled as a word.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? lo[0] : |lo;
   endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: load lane extract with sign/zero extension, and store lane merge into a RAM word.
module mem_lane_unit
   import mem_bridge_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        zext,
   input  logic [1:0]  lo,
   input  logic [31:0] rdata,
   input  logic [31:0] merge,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);
   logic [7:0]  b;
   logic [15:0] h;

   // Halfword lane uses only lo[1], so a misaligned half is truncated naturally.
   always_comb begin
      b = rdata[{lo, 3'b000} +: 8];
      h = rdata[{lo[1], 4'b0000} +: 16];
      load_data = size == SIZE_BYTE ? {{24{~zext & b[7]}}, b} :
                  size == SIZE_HALF ? {{16{~zext & h[15]}}, h} : rdata;
      store_data = merge;
      if (size == SIZE_BYTE)
         store_data[{lo, 3'b000} +: 8] = wdata[7:0];
      else if (size == SIZE_HALF)
         store_data[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      else
         store_data = wdata;
   end
endmodule

// File: rtl/mem_rmw_bridge.sv
// mem_rmw_bridge: byte/half/word req/ack bridge to a word-only RAM, read-modify-write for sub-word stores.
// Define MEM_BRIDGE_MISALIGN_TRAP_EN to answer misaligned requests with err_o instead of truncating them.
module mem_rmw_bridge
   import mem_bridge_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              ack_o,
   output logic              err_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);
   state_t      state, state_nx;
   logic        we_q, uns_q, trap;
   logic [1:0]  size_q, lo_q;
   logic [31:0] wdata_q, merge_q, load_data, store_data;

`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
   logic err_q;
   assign trap  = misaligned(size_i, addr_i[1:0]);
   assign err_o = ack_o & err_q;
   always_ff @(posedge clk)
      if (rst) err_q <= 1'b0;
      else if (state == IDLE && req_i) err_q <= trap;
`else
   assign trap  = 1'b0;
   assign err_o = 1'b0;
`endif

   mem_lane_unit lane (
      .size      (size_q),
      .zext      (uns_q),
      .lo        (lo_q),
      .rdata     (ram_rdata_i),
      .merge     (merge_q),
      .wdata     (wdata_q),
      .load_data (load_data),
      .store_data(store_data)
   );

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;

   always_comb
      state_nx = state == IDLE   ? (req_i ? (trap ? RESP : ACCESS) : IDLE) :
                 state == ACCESS ? (we_q && !size_q[1] ? WRITE : RESP) :
                 state == WRITE  ? RESP : IDLE;

   // Reset gates the write strobe so an interrupted store never commits.
   always_comb begin
      ack_o       = state == RESP;
      ram_we_o    = !rst && (state == WRITE || (state == ACCESS && we_q && size_q[1]));
      ram_wdata_o = ram_we_o ? store_data : '0;
   end

   always_ff @(posedge clk)
      if (rst) begin
         rdata_o    <= '0;
         ram_addr_o <= '0;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= '0;
         lo_q       <= '0;
         wdata_q    <= '0;
         merge_q    <= '0;
      end else begin
         if (state == IDLE && req_i) begin
            we_q       <= we_i;
            uns_q      <= unsigned_i;
            size_q     <= size_i;
            lo_q       <= addr_i[1:0];
            wdata_q    <= wdata_i;
            ram_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
         end
         if (state == ACCESS && !we_q) rdata_o <= load_data;
         if (state == ACCESS) merge_q <= ram_rdata_i;
      end
endmodule

// File: tb/tb_mem_rmw_bridge.sv
// tb_mem_rmw_bridge: vector table, corner sequences and randomized traffic against a word-array RAM model.
module tb_mem_rmw_bridge;
   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata, last_wd;
   logic        ack, err, ram_we;
   logic [31:0] mem [0:1023];
   logic [31:0] ref_mem [0:15];
   int          wr_cnt = 0, total = 0, bad = 0;

   always #5 clk = ~clk;

   mem_rmw_bridge #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .size_i(size), .unsigned_i(uns),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .err_o(err),
      .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   assign ram_rdata = mem[ram_addr[11:2]];

   always @(posedge clk)
      if (ram_we) begin
         mem[ram_addr[11:2]] <= ram_wdata;
         wr_cnt <= wr_cnt + 1;
         last_wd <= ram_wdata;
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic xact(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd, output logic er);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
      @(posedge clk);
      lat = -1; rd = '0; er = 1'b0;
      for (int c = 1; c <= 6 && lat < 0; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (ack) begin lat = c; rd = rdata; er = err; end
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      int l; logic [31:0] r; logic e;
      xact(1'b1, 2'b10, 1'b0, a, d, l, r, e);
   endtask

   function automatic logic [31:0] ref_ld(input logic [31:0] w, input logic [1:0] sz, input logic u, input logic [1:0] a);
      int unsigned v;
      if (sz == 2'd0) begin
         v = (w >> (8 * a)) & 'hFF;
         if (!u && v >= 'h80) v += 'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * a[1])) & 'hFFFF;
         if (!u && v >= 'h8000) v += 'hFFFF0000;
      end else v = w;
      return v;
   endfunction

   function automatic logic [31:0] ref_st(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] a, input logic [31:0] d);
      int unsigned sh, m;
      if (sz >= 2'd2) return d;
      sh = sz == 2'd0 ? 8 * a : 16 * a[1];
      m = (sz == 2'd0 ? 'hFF : 'hFFFF) << sh;
      return (w & ~m) | ((d << sh) & m);
   endfunction

   typedef struct {
      logic        pre;
      logic [31:0] init;
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a, d, exp;
      int          lat;
   } vec_t;

   initial begin
      vec_t        v [11];
      int          lat, w0, acks, exp_lat;
      logic [31:0] rd, prev, d, a;
      logic        er, w, u, mis, trap;
      logic [1:0]  sz, lo;
      logic [3:0]  idx;

      v[0]  = '{1'b1, 32'h8899AABB, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'hFFFFFFAA, 2};
      v[1]  = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        32'h000000AA, 2};
      v[2]  = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'hFFFFFF88, 2};
      v[3]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h100, 32'h0,        32'h0000AABB, 2};
      v[4]  = '{1'b1, 32'h11223344, 1'b1, 2'd0, 1'b0, 32'h202, 32'h000000EE, 32'h11EE3344, 3};
      v[5]  = '{1'b0, 32'h0,        1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        32'h11EE3344, 2};
      v[6]  = '{1'b1, 32'hCAFE0000, 1'b1, 2'd1, 1'b0, 32'h302, 32'h0000BEEF, 32'hBEEF0000, 3};
      v[7]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b0, 32'h302, 32'h0,        32'hFFFFBEEF, 2};
      v[8]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h302, 32'h0,        32'h0000BEEF, 2};
      v[9]  = '{1'b1, 32'h0,        1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, 32'hDEADBEEF, 2};
      v[10] = '{1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 32'h400, 32'h0,        32'hDEADBEEF, 2};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_addr", ram_addr, 32'd0);
      chk("rst_wdata", ram_wdata, 32'd0);

      foreach (v[i]) begin
         if (v[i].pre) poke(v[i].a & ~32'h3, v[i].init);
         w0 = wr_cnt;
         xact(v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d, lat, rd, er);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(v[i].lat));
         chk($sformatf("vec%0d_err", i), {31'd0, er}, 32'd0);
         chk($sformatf("vec%0d_data", i), v[i].w ? mem[v[i].a[11:2]] : rd, v[i].exp);
         chk($sformatf("vec%0d_writes", i), 32'(wr_cnt - w0), v[i].w ? 32'd1 : 32'd0);
      end

      // misaligned word store
      poke(32'h400, 32'h0BADF00D);
      w0 = wr_cnt;
      xact(1'b1, 2'd2, 1'b0, 32'h403, 32'h12345678, lat, rd, er);
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
      chk("mis_lat", 32'(lat), 32'd1);
      chk("mis_err", {31'd0, er}, 32'd1);
      chk("mis_mem", mem[32'h400 >> 2], 32'h0BADF00D);
      chk("mis_writes", 32'(wr_cnt - w0), 32'd0);
`else
      chk("mis_lat", 32'(lat), 32'd2);
      chk("mis_err", {31'd0, er}, 32'd0);
      chk("mis_mem", mem[32'h400 >> 2], 32'h12345678);
      chk("mis_writes", 32'(wr_cnt - w0), 32'd1);
`endif

      // request held high for six cycles: two accepted stores
      poke(32'h700, 32'h0);
      w0 = wr_cnt; acks = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h700; wdata = 32'hDEADBEEF;
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
         if (ack) acks++;
      end
      req = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ack) acks++;
      end
      chk("held_acks", 32'(acks), 32'd2);
      chk("held_writes", 32'(wr_cnt - w0), 32'd2);
      chk("held_wdata", last_wd, 32'hDEADBEEF);
      chk("held_mem", mem[32'h700 >> 2], 32'hDEADBEEF);

      // reset while a byte store sits in its write cycle
      poke(32'h600, 32'h55667788);
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h601; wdata = 32'h99;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("rmw_we_write", {31'd0, ram_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rmw_we_in_rst", {31'd0, ram_we}, 32'd0);
      w0 = wr_cnt;
      @(negedge clk);
      rst = 1'b0;
      chk("rmw_writes", 32'(wr_cnt - w0), 32'd0);
      chk("rmw_mem", mem[32'h600 >> 2], 32'h55667788);
      chk("rmw_ack", {31'd0, ack}, 32'd0);
      chk("rmw_err", {31'd0, err}, 32'd0);
      chk("rmw_rdata", rdata, 32'd0);
      chk("rmw_addr", ram_addr, 32'd0);
      chk("rmw_wdata", ram_wdata, 32'd0);
      xact(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, lat, rd, er);
      chk("rmw_after_lat", 32'(lat), 32'd2);
      chk("rmw_after_data", rd, 32'h55667788);

      // randomized traffic against the word-array model
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         poke(32'h800 + 32'(4 * i), ref_mem[i]);
      end
      for (int n = 0; n < 200; n++) begin
         w   = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         u   = 1'($urandom_range(0, 1));
         idx = 4'($urandom_range(0, 15));
         lo  = 2'($urandom_range(0, 3));
         d   = $urandom;
         a   = 32'h800 + 32'(idx) * 4 + 32'(lo);
         mis = sz == 2'd1 ? lo[0] : sz >= 2'd2 ? (lo != 2'd0) : 1'b0;
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
         trap = mis;
`else
         trap = 1'b0;
`endif
         exp_lat = trap ? 1 : (w && sz < 2'd2) ? 3 : 2;
         prev = rdata;
         xact(w, sz, u, a, d, lat, rd, er);
         chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
         chk($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, trap});
         if (w) begin
            if (!trap) ref_mem[idx] = ref_st(ref_mem[idx], sz, lo, d);
            chk($sformatf("rnd%0d_mem", n), mem[10'h200 + 10'(idx)], ref_mem[idx]);
         end else
            chk($sformatf("rnd%0d_load", n), rd, trap ? prev : ref_ld(ref_mem[idx], sz, u, lo));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_rmw_bridge.md
Name: mem_rmw_bridge

Overview:
Upstream adapter between the core's load/store unit and the word-only peripheral RAM. The RAM has combinational read, full-word write on the clock edge, and is indexed by addr[31:2].
- Converts byte/halfword/word requests with a req/ack handshake into RAM accesses.
- Sub-word stores use a read-modify-write sequence.
- Sub-word loads return sign- or zero-extended data.

Parameters:
ADDR_W, 32, byte-address width on both sides; data path fixed at 32 bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_i  in  1  request valid; held stable by the core until ack_o
we_i  in  1  1 = store, 0 = load
size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
unsigned_i  in  1  load zero-extend (lbu/lhu); ignored for stores and word loads
addr_i  in  ADDR_W  byte address
wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rdata_o  out  32  extended load data; valid when ack_o=1, held until next load completes
ack_o  out  1  one-cycle completion pulse
err_o  out  1  misaligned-access flag, pulses with ack_o (see Optional Feature)
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_W  RAM address, bits [1:0] always 0
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM combinational read data

Behaviour:
- Reset (rst=1 at posedge): state IDLE; ack_o, err_o, rdata_o, ram_addr_o, ram_wdata_o = 0.
- ram_we_o is forced 0 in any cycle where rst=1, so a reset mid-operation never commits a write.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - On req_i=1, latch we, size, unsigned, addr, wdata.
  - Drive ram_addr_o = {addr[ADDR_W-1:2], 2'b00}; go to ACCESS.
  - Requests are accepted only in IDLE.
- ACCESS, load: extract lane from ram_rdata_i by addr[1:0]/size, then extend:
  - byte: lane (addr[1:0]*8), extended from bit 7
  - half: lane (addr[1]*16), extended from bit 15
  - word: unchanged
  - Register result into rdata_o; go to RESP.
- ACCESS, word store: ram_we_o=1, ram_wdata_o = latched wdata; go to RESP.
- ACCESS, sub-word store: capture ram_rdata_i into merge register; go to WRITE.
- WRITE:
  - ram_we_o=1.
  - ram_wdata_o = merge register with the selected byte/half lane replaced by wdata[7:0]/[15:0]; other lanes preserved.
  - Go to RESP.
- RESP: ack_o=1 for exactly one cycle; return to IDLE. A req_i still high in the following IDLE cycle is a new request.
- Latency (accept edge = cycle 0):
  - loads and word stores: ack_o high in cycle 2
  - sub-word stores: ack_o high in cycle 3
- Throughput: one request per 3 cycles (loads/word stores) or 4 cycles (sub-word stores).
- ram_addr_o stays stable from ACCESS through WRITE; the RAM sees exactly one write per store.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. Handling is defined in Optional Feature.
- Back-to-back store then load to the same word: the load must return the merged value. Guaranteed, since the write commits before RESP.

Optional Feature:
Macro MEM_BRIDGE_MISALIGN_TRAP_EN.
- Defined: a misaligned request skips ACCESS/WRITE and goes IDLE→RESP.
  - No RAM write is issued; rdata_o is unchanged.
  - err_o=1 together with ack_o (ack in cycle 1).
- Undefined: err_o is tied 0. Address low bits are truncated to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.

Decomposition:
- Shared package mem_bridge_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - FSM state encoding
  - misalignment check function
- One combinational sub-module, mem_lane_unit: load lane extract + sign/zero extension and store lane merge.
- The FSM stays in mem_rmw_bridge.

Test Plan:
- RAM word 0x100 = 0x8899AABB; lb 0x101 → rdata_o=0xFFFFFFAA, ack in cycle 2; lbu 0x101 → 0x000000AA.
- Word 0x200 = 0x11223344; sb 0x202 data 0xEE → exactly one ram_we_o pulse, RAM = 0x11EE3344, ack in cycle 3; following lw 0x200 returns 0x11EE3344.
- sh 0x302 data 0xBEEF over 0xCAFE0000 → 0xBEEF0000; lh 0x302 → 0xFFFFBEEF; lhu → 0x0000BEEF.
- sw 0x400 0xDEADBEEF with req_i held 6 cycles → two acks, one per accepted request, two writes of identical data, no third write.
- rst asserted during WRITE of an sb → ram_we_o=0 that cycle, RAM word unchanged, all outputs 0 next cycle, FSM in IDLE.
- With MEM_BRIDGE_MISALIGN_TRAP_EN: sw 0x403 → ack+err in cycle 1, no write. Without the macro: same request writes word 0x400, err_o=0.
